ethernet_tx_framer: RTL and testbench

Ethernet transmit framer that sits directly downstream of the MAC register block. It pops one TX descriptor (destination MAC, payload length) and the matching payload bytes from the register block's buffers. It emits a complete byte-wide frame (preamble, SFD, header, payload, zero padding, FCS), then enforces the inter-frame gap. Output goes through a valid/ready handshake to the PHY-side serializer; `tx_idle_o` feeds the register block's TX-done interrupt and status logic.

---
 rtl/ethernet_tx_framer_pkg.sv | 24 ++
 rtl/ethernet_crc32.sv | 24 ++
 rtl/ethernet_tx_framer.sv | 252 +++++++++++++++++++++++++
 tb/tb_ethernet_tx_framer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_tx_framer_pkg.sv
// Shared Ethernet definitions: framer state encoding, framing constants and the
// byte-wide reflected CRC-32 step used by both the TX framer and the RX checker.
package ethernet_tx_framer_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, PREAMBLE, SFD, DEST, SRC, LEN,
        PAYLOAD, PAD, FCS, IFG, DRAIN
    } eth_tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

    function automatic logic [31:0] eth_crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// Running CRC-32 (reflected, init all-ones), one byte per enabled cycle.
// crc_o is the registered remainder; clear_i has priority over enable_i.
module ethernet_crc32
    import ethernet_tx_framer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_o <= ETH_CRC_INIT;
        end else if (clear_i) begin
            crc_o <= ETH_CRC_INIT;
        end else if (enable_i) begin
            crc_o <= eth_crc32_byte(crc_o, data_i);
        end
    end

endmodule

// File: rtl/ethernet_tx_framer.sv
// Byte-wide Ethernet TX framer: descriptor + payload in, preamble..FCS out, then IFG.
// First byte 3 cycles after data_ready_i; output register holds until tx_ready_i, no bubbles.
module ethernet_tx_framer
    import ethernet_tx_framer_pkg::*;
#(
    parameter logic [47:0] SOURCE_MAC     = 48'h02_00_00_00_00_00,
    parameter int          MAX_PAYLOAD    = 1500,
    parameter int          MIN_PAYLOAD    = 46,
    parameter int          PREAMBLE_BYTES = 7,
    parameter int          IFG_BYTES      = 12
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            data_ready_i,
    input  logic [5:0][7:0] dest_address_i,
    input  logic [1:0][7:0] payload_length_i,
    input  logic [7:0]      payload_i,
    output logic            read_descriptor_o,
    output logic            read_payload_o,
    output logic            tx_idle_o,
    output logic [7:0]      tx_data_o,
    output logic            tx_valid_o,
    output logic            tx_last_o,
    input  logic            tx_ready_i,
    output logic            length_error_o
);

    localparam logic [5:0][7:0] SRC_OCT = SOURCE_MAC;
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

    eth_tx_state_t   state;
    logic [15:0]     cnt;
    logic [15:0]     len_q;
    logic [15:0]     req_cnt;
    logic [5:0][7:0] dest_q;

    logic [7:0]      skid_mem [2];
    logic            skid_wr;
    logic            skid_rd;
    logic [1:0]      skid_occ;
    logic            rd_pend;

    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic            fire;
    logic            pop;
    logic            bypass;
    logic            push;
    logic            issue;
    logic            crc_en;
    logic [7:0]      head;
    logic [2:0]      inflight;

    assign fire     = tx_valid_o & tx_ready_i;
    // An empty skid buffer forwards the byte arriving this cycle straight to the output.
    assign head     = (skid_occ != 2'd0) ? skid_mem[skid_rd] : payload_i;
    assign pop      = fire & (((state == LEN) & (cnt == 16'd1) & (len_q != 16'd0)) |
                              ((state == PAYLOAD) & (cnt != len_q - 16'd1)));
    assign bypass   = pop & (skid_occ == 2'd0);
    assign push     = rd_pend & ~bypass & (state != IDLE) & (state != DRAIN);
    assign inflight = {1'b0, skid_occ} + {2'b0, read_payload_o} + {2'b0, rd_pend};
    // Reads already issued or in flight count against the two skid slots, net of this cycle's pop.
    assign issue    = (state inside {DEST, SRC, LEN, PAYLOAD, DRAIN}) & (req_cnt < len_q) &
                      ((state == DRAIN) | (inflight < (3'd2 + {2'b0, pop})));
    assign crc_en   = fire & (state inside {DEST, SRC, LEN, PAYLOAD, PAD});
    assign crc_next = eth_crc32_byte(crc, tx_data_o);

    ethernet_crc32 u_crc (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (state == LATCH),
        .enable_i (crc_en),
        .data_i   (tx_data_o),
        .crc_o    (crc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_mem[0] <= 8'd0;
            skid_mem[1] <= 8'd0;
            skid_wr     <= 1'b0;
            skid_rd     <= 1'b0;
            skid_occ    <= 2'd0;
            rd_pend     <= 1'b0;
        end else begin
            rd_pend <= read_payload_o;
            if (state == LATCH) begin
                skid_wr  <= 1'b0;
                skid_rd  <= 1'b0;
                skid_occ <= 2'd0;
            end else begin
                if (push) begin
                    skid_mem[skid_wr] <= payload_i;
                    skid_wr           <= ~skid_wr;
                end
                if (pop & ~bypass) begin
                    skid_rd <= ~skid_rd;
                end
                skid_occ <= skid_occ + {1'b0, push} - {1'b0, pop & ~bypass};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state             <= IDLE;
            cnt               <= 16'd0;
            len_q             <= 16'd0;
            req_cnt           <= 16'd0;
            dest_q            <= '0;
            tx_idle_o         <= 1'b1;
            tx_data_o         <= 8'd0;
            tx_valid_o        <= 1'b0;
            tx_last_o         <= 1'b0;
            read_descriptor_o <= 1'b0;
            read_payload_o    <= 1'b0;
            length_error_o    <= 1'b0;
        end else begin
            read_descriptor_o <= 1'b0;
            length_error_o    <= 1'b0;
            read_payload_o    <= issue;
            req_cnt           <= req_cnt + {15'd0, issue};
            unique case (state)
                IDLE: if (data_ready_i) begin
                    state             <= FETCH;
                    tx_idle_o         <= 1'b0;
                    read_descriptor_o <= 1'b1;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    dest_q  <= dest_address_i;
                    len_q   <= payload_length_i;
                    req_cnt <= 16'd0;
                    cnt     <= 16'd0;
                    if (payload_length_i > MAX_LEN) begin
                        length_error_o <= 1'b1;
                        state          <= DRAIN;
                    end else begin
                        state      <= PREAMBLE;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= ETH_PREAMBLE;
                    end
                end
                PREAMBLE: if (fire) begin
                    if (cnt == PRE_LAST) begin
                        state     <= SFD;
                        cnt       <= 16'd0;
                        tx_data_o <= ETH_SFD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SFD: if (fire) begin
                    state     <= DEST;
                    tx_data_o <= dest_q[5];
                end
                DEST: if (fire) begin
                    if (cnt == 16'd5) begin
                        state     <= SRC;
                        cnt       <= 16'd0;
                        tx_data_o <= SRC_OCT[5];
                    end else begin
                        cnt       <= cnt + 16'd1;
                        tx_data_o <= dest_q[3'd4 - cnt[2:0]];
                    end
                end
                SRC: if (fire) begin
                    if (cnt == 16'd5) begin
                        state     <= LEN;
                        cnt       <= 16'd0;
                        tx_data_o <= len_q[15:8];
                    end else begin
                        cnt       <= cnt + 16'd1;
                        tx_data_o <= SRC_OCT[3'd4 - cnt[2:0]];
                    end
                end
                LEN: if (fire) begin
                    if (cnt == 16'd0) begin
                        cnt       <= 16'd1;
                        tx_data_o <= len_q[7:0];
                    end else begin
                        state     <= (len_q == 16'd0) ? PAD : PAYLOAD;
                        cnt       <= 16'd0;
                        tx_data_o <= (len_q == 16'd0) ? 8'd0 : head;
                    end
                end
                PAYLOAD: if (fire) begin
                    if (cnt == len_q - 16'd1) begin
                        if (len_q < MIN_LEN) begin
                            state     <= PAD;
                            cnt       <= len_q;
                            tx_data_o <= 8'd0;
                        end else begin
                            state     <= FCS;
                            cnt       <= 16'd0;
                            tx_data_o <= ~crc_next[7:0];
                        end
                    end else begin
                        cnt       <= cnt + 16'd1;
                        tx_data_o <= head;
                    end
                end
                PAD: if (fire) begin
                    if (cnt == MIN_LEN - 16'd1) begin
                        state     <= FCS;
                        cnt       <= 16'd0;
                        tx_data_o <= ~crc_next[7:0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                // The remainder settles one cycle after the last covered byte, so bytes 1..3 read crc.
                FCS: if (fire) begin
                    cnt <= cnt + 16'd1;
                    case (cnt[1:0])
                        2'd0: tx_data_o <= ~crc[15:8];
                        2'd1: tx_data_o <= ~crc[23:16];
                        2'd2: begin
                            tx_data_o <= ~crc[31:24];
                            tx_last_o <= 1'b1;
                        end
                        default: begin
                            state      <= IFG;
                            cnt        <= 16'd0;
                            tx_valid_o <= 1'b0;
                            tx_last_o  <= 1'b0;
                            tx_data_o  <= 8'd0;
                        end
                    endcase
                end
                IFG: if (tx_ready_i) begin
                    if (cnt == IFG_LAST) begin
                        state     <= IDLE;
                        cnt       <= 16'd0;
                        tx_idle_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DRAIN: if (req_cnt == len_q) begin
                    state     <= IDLE;
                    tx_idle_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Scoreboard bench: stimulus queues descriptors and expected bytes, a negedge monitor checks output.
module tb_ethernet_tx_framer;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            data_ready_i = 1'b0;
    logic [5:0][7:0] dest_address_i = '0;
    logic [1:0][7:0] payload_length_i = '0;
    logic [7:0]      payload_i = 8'd0;
    logic            read_descriptor_o;
    logic            read_payload_o;
    logic            tx_idle_o;
    logic [7:0]      tx_data_o;
    logic            tx_valid_o;
    logic            tx_last_o;
    logic            tx_ready_i = 1'b1;
    logic            length_error_o;

    ethernet_tx_framer dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .data_ready_i      (data_ready_i),
        .dest_address_i    (dest_address_i),
        .payload_length_i  (payload_length_i),
        .payload_i         (payload_i),
        .read_descriptor_o (read_descriptor_o),
        .read_payload_o    (read_payload_o),
        .tx_idle_o         (tx_idle_o),
        .tx_data_o         (tx_data_o),
        .tx_valid_o        (tx_valid_o),
        .tx_last_o         (tx_last_o),
        .tx_ready_i        (tx_ready_i),
        .length_error_o    (length_error_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    logic [8:0]  exp_q[$];
    logic [47:0] desc_dest_q[$];
    logic [15:0] desc_len_q[$];
    logic [7:0]  pay_q[$];
    logic [47:0] src_mac = 48'h02_00_00_00_00_00;
    int rd_pay_cnt = 0;
    int err_cnt = 0;
    int idle_rise = 0;
    int bytes_acc = 0;
    int cyc = 0;
    int last_cyc = 0;
    int gap = -1;
    bit gap_armed = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic queue_frame(input logic [47:0] dest, input int len, input logic [7:0] pat);
        logic [7:0]  body[$];
        logic [31:0] c;
        for (int k = 0; k < len; k++) pay_q.push_back(pat + 8'(k * 17));
        if (len <= 1500) begin
            for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'hD5});
            for (int i = 5; i >= 0; i--) body.push_back(dest[i*8 +: 8]);
            for (int i = 5; i >= 0; i--) body.push_back(src_mac[i*8 +: 8]);
            body.push_back(8'(len >> 8));
            body.push_back(8'(len));
            for (int k = 0; k < len; k++) body.push_back(pat + 8'(k * 17));
            for (int k = len; k < 46; k++) body.push_back(8'h00);
            c = 32'hFFFFFFFF;
            foreach (body[i]) begin
                c = ref_crc(c, body[i]);
                exp_q.push_back({1'b0, body[i]});
            end
            c = ~c;
            for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), c[i*8 +: 8]});
        end
        desc_dest_q.push_back(dest);
        desc_len_q.push_back(16'(len));
    endtask

    // Descriptor and payload buffers: registered read data appears the cycle after the pop.
    initial begin
        logic rd_d, rd_p;
        forever begin
            @(negedge clk_i);
            rd_d = read_descriptor_o;
            rd_p = read_payload_o;
            @(posedge clk_i);
            #1;
            if (rd_d && desc_len_q.size() != 0) begin
                dest_address_i   = desc_dest_q.pop_front();
                payload_length_i = desc_len_q.pop_front();
            end
            if (rd_p) begin
                rd_pay_cnt++;
                payload_i = (pay_q.size() != 0) ? pay_q.pop_front() : 8'hEE;
            end
            data_ready_i = (desc_len_q.size() != 0);
        end
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        tx_ready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
    end

    // Monitor: scoreboard pops on every accepted byte, and a stalled byte must hold.
    initial begin
        logic       stall_q;
        logic [8:0] stall_v;
        logic [8:0] e;
        logic       prev_idle;
        stall_q   = 1'b0;
        stall_v   = 9'd0;
        prev_idle = 1'b1;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_n_i) begin
                stall_q   = 1'b0;
                prev_idle = tx_idle_o;
            end else begin
                if (length_error_o) err_cnt++;
                if (tx_idle_o && !prev_idle) idle_rise++;
                prev_idle = tx_idle_o;
                if (stall_q) begin
                    check("hold_valid", 32'(tx_valid_o), 32'd1);
                    check("hold_data", 32'({tx_last_o, tx_data_o}), 32'(stall_v));
                end
                stall_q = 1'b0;
                if (tx_valid_o) begin
                    if (gap_armed) begin
                        gap       = cyc - last_cyc - 1;
                        gap_armed = 0;
                    end
                    if (tx_ready_i) begin
                        bytes_acc++;
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("byte%0d", bytes_acc), 32'({tx_last_o, tx_data_o}), 32'(e));
                        end
                        if (tx_last_o) begin
                            last_cyc  = cyc;
                            gap_armed = 1;
                        end
                    end else begin
                        stall_q = 1'b1;
                        stall_v = {tx_last_o, tx_data_o};
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        repeat (3) @(posedge clk_i);
        while ((exp_q.size() != 0 || desc_len_q.size() != 0 || !tx_idle_o) && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        repeat (3) @(posedge clk_i);
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d cycles, expected < %0d", name, n, budget);
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int b0, r0, e0, i0, n;
        #12;
        check("rst_idle", 32'(tx_idle_o), 32'd1);
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        check("rst_last", 32'(tx_last_o), 32'd0);
        check("rst_rd_desc", 32'(read_descriptor_o), 32'd0);
        check("rst_rd_pay", 32'(read_payload_o), 32'd0);
        check("rst_len_err", 32'(length_error_o), 32'd0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);

        // Basic frame with start-up latency probe
        b0 = bytes_acc; r0 = rd_pay_cnt;
        queue_frame(48'h02_00_00_00_00_01, 4, 8'hAA);
        n = 0;
        do begin @(negedge clk_i); n++; end while (!data_ready_i && n < 20);
        @(negedge clk_i);
        check("lat_rd_desc", 32'(read_descriptor_o), 32'd1);
        @(negedge clk_i);
        check("lat_latch_valid", 32'(tx_valid_o), 32'd0);
        @(negedge clk_i);
        check("lat_first_valid", 32'(tx_valid_o), 32'd1);
        check("lat_first_data", 32'(tx_data_o), 32'h55);
        wait_done("basic", 500);
        check("basic_bytes", 32'(bytes_acc - b0), 32'd72);
        check("basic_reads", 32'(rd_pay_cnt - r0), 32'd4);

        // Zero length: all pad
        b0 = bytes_acc; r0 = rd_pay_cnt;
        queue_frame(48'h10_20_30_40_50_60, 0, 8'h00);
        wait_done("zero", 500);
        check("zero_bytes", 32'(bytes_acc - b0), 32'd72);
        check("zero_reads", 32'(rd_pay_cnt - r0), 32'd0);

        // Random backpressure, length 100
        ready_mode = 1;
        b0 = bytes_acc; r0 = rd_pay_cnt;
        queue_frame(48'hA1_B2_C3_D4_E5_F6, 100, 8'h10);
        wait_done("bp", 5000);
        check("bp_bytes", 32'(bytes_acc - b0), 32'd126);
        check("bp_reads", 32'(rd_pay_cnt - r0), 32'd100);
        ready_mode = 0;
        repeat (2) @(posedge clk_i);

        // Back-to-back descriptors
        b0 = bytes_acc; r0 = rd_pay_cnt; i0 = idle_rise;
        queue_frame(48'h02_00_00_00_00_01, 4, 8'h01);
        queue_frame(48'h02_00_00_00_00_02, 60, 8'h40);
        wait_done("b2b", 1000);
        check("b2b_gap", 32'(gap), 32'd15);
        check("b2b_idle_rises", 32'(idle_rise - i0), 32'd2);
        check("b2b_bytes", 32'(bytes_acc - b0), 32'd158);
        check("b2b_reads", 32'(rd_pay_cnt - r0), 32'd64);

        // Oversize length is drained without transmitting
        b0 = bytes_acc; r0 = rd_pay_cnt; e0 = err_cnt;
        queue_frame(48'h02_00_00_00_00_03, 1501, 8'h05);
        wait_done("oversize", 4000);
        check("over_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("over_reads", 32'(rd_pay_cnt - r0), 32'd1501);
        check("over_bytes", 32'(bytes_acc - b0), 32'd0);
        check("over_idle", 32'(tx_idle_o), 32'd1);

        // Reset during payload byte 10, then a clean frame
        b0 = bytes_acc;
        queue_frame(48'h02_00_00_00_00_04, 20, 8'h30);
        n = 0;
        do begin @(posedge clk_i); n++; end while ((bytes_acc - b0) < 32 && n < 500);
        check("mid_reached", 32'(bytes_acc - b0), 32'd32);
        #2 rst_n_i = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx_valid_o), 32'd0);
        check("mid_rst_idle", 32'(tx_idle_o), 32'd1);
        check("mid_rst_data", 32'(tx_data_o), 32'd0);
        check("mid_rst_last", 32'(tx_last_o), 32'd0);
        check("mid_rst_rd_pay", 32'(read_payload_o), 32'd0);
        exp_q.delete(); pay_q.delete(); desc_dest_q.delete(); desc_len_q.delete();
        payload_i = 8'd0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        b0 = bytes_acc; r0 = rd_pay_cnt;
        queue_frame(48'h02_00_00_00_00_05, 50, 8'h77);
        wait_done("post_rst", 500);
        check("post_rst_bytes", 32'(bytes_acc - b0), 32'd76);
        check("post_rst_reads", 32'(rd_pay_cnt - r0), 32'd50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
